// File: rtl/baud_rate_ctrl.sv
// Baud rate configuration sequencer.
// Accepts a preset or custom divisor request and waits for the transmitter to drain.
// It then writes the divisor to the baud generator, low byte first, and holds the
// transmitter off until the new rate has settled. A default rate is loaded after reset.
module baud_rate_ctrl #(
   parameter logic [15:0] DIV_4800     = 16'd651,
   parameter logic [15:0] DIV_9600     = 16'd326,
   parameter logic [15:0] DIV_19200    = 16'd163,
   parameter logic [15:0] DIV_38400    = 16'd81,
   parameter logic [1:0]  DEFAULT_CODE = 2'b01,
   parameter int unsigned DRAIN_MAX    = 4096,
   parameter int unsigned SETTLE_CYC   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_custom,
   input  logic [1:0]  req_code,
   input  logic [15:0] req_div,
   input  logic        tx_busy,
   output logic        tx_hold,
   output logic        baud_write_en,
   output logic        baud_write_location,
   output logic [7:0]  baud_generator_write_line,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic [15:0] cur_div
);

   localparam logic [12:0] DRAIN_LAST  = 13'(DRAIN_MAX - 1);
   localparam logic [4:0]  SETTLE_LAST = 5'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {StInit, StIdle, StDrain, StWrLo, StWrHi, StSettle} state_e;

   state_e      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [12:0] drain_cnt_q, drain_cnt_d;
   logic [4:0]  settle_cnt_q, settle_cnt_d;
   logic [15:0] cur_div_q, cur_div_d;
   logic        cfg_err_q, cfg_err_d;
   logic        cfg_done_q, cfg_done_d;

   function automatic logic [15:0] preset(input logic [1:0] code);
      logic [15:0] d;
      unique case (code)
         2'b00:   d = DIV_4800;
         2'b01:   d = DIV_9600;
         2'b10:   d = DIV_19200;
         default: d = DIV_38400;
      endcase
      return d;
   endfunction

   // State and datapath registers; reset restarts with the default rate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StInit;
         div_q        <= preset(DEFAULT_CODE);
         drain_cnt_q  <= '0;
         settle_cnt_q <= '0;
         cur_div_q    <= '0;
         cfg_err_q    <= 1'b0;
         cfg_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         drain_cnt_q  <= drain_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         cur_div_q    <= cur_div_d;
         cfg_err_q    <= cfg_err_d;
         cfg_done_q   <= cfg_done_d;
      end
   end

   // Next-state logic for the sequencer.
   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      drain_cnt_d  = drain_cnt_q;
      settle_cnt_d = settle_cnt_q;
      cur_div_d    = cur_div_q;
      cfg_err_d    = cfg_err_q;
      cfg_done_d   = 1'b0;
      unique case (state_q)
         StInit: state_d = StWrLo;
         StIdle: begin
            if (req_valid) begin
               if (req_custom && (req_div == 16'h0000)) begin
                  cfg_err_d = 1'b1;
               end else begin
                  div_d       = req_custom ? req_div : preset(req_code);
                  cfg_err_d   = 1'b0;
                  drain_cnt_d = '0;
                  state_d     = StDrain;
               end
            end
         end
         StDrain: begin
            if (!tx_busy) begin
               state_d = StWrLo;
            end else if (drain_cnt_q == DRAIN_LAST) begin
               // Transmitter never went idle: give up without touching the generator.
               cfg_err_d = 1'b1;
               state_d   = StIdle;
            end else begin
               drain_cnt_d = drain_cnt_q + 13'd1;
            end
         end
         StWrLo: state_d = StWrHi;
         StWrHi: begin
            settle_cnt_d = '0;
            state_d      = StSettle;
         end
         StSettle: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               cfg_done_d = 1'b1;
               cur_div_d  = div_q;
               state_d    = StIdle;
            end else begin
               settle_cnt_d = settle_cnt_q + 5'd1;
            end
         end
         default: state_d = StInit;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      req_ready                 = (state_q == StIdle);
      tx_hold                   = (state_q != StIdle);
      baud_write_en             = (state_q == StWrLo) || (state_q == StWrHi);
      baud_write_location       = (state_q == StWrHi);
      baud_generator_write_line = 8'h00;
      if (state_q == StWrLo) baud_generator_write_line = div_q[7:0];
      if (state_q == StWrHi) baud_generator_write_line = div_q[15:8];
   end

   assign cfg_done = cfg_done_q;
   assign cfg_err  = cfg_err_q;
   assign cur_div  = cur_div_q;

endmodule

// File: tb/tb_baud_rate_ctrl.sv
// Self-checking bench for baud_rate_ctrl: table vectors, random requests against a
// timing/value model, and hand-written sequences for timeout, reject and mid-write reset.
module tb_baud_rate_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_custom;
   logic [1:0]  req_code;
   logic [15:0] req_div;
   logic        tx_busy;
   logic        tx_hold;
   logic        baud_write_en;
   logic        baud_write_location;
   logic [7:0]  baud_generator_write_line;
   logic        cfg_done;
   logic        cfg_err;
   logic [15:0] cur_div;

   int total  = 0;
   int passed = 0;

   baud_rate_ctrl dut (
      .clk                       (clk),
      .rst                       (rst),
      .req_valid                 (req_valid),
      .req_ready                 (req_ready),
      .req_custom                (req_custom),
      .req_code                  (req_code),
      .req_div                   (req_div),
      .tx_busy                   (tx_busy),
      .tx_hold                   (tx_hold),
      .baud_write_en             (baud_write_en),
      .baud_write_location       (baud_write_location),
      .baud_generator_write_line (baud_generator_write_line),
      .cfg_done                  (cfg_done),
      .cfg_err                   (cfg_err),
      .cur_div                   (cur_div)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        custom;
      logic [1:0]  code;
      logic [15:0] div;
      int          busy;
      logic [15:0] exp_div;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   // Reference: divisor chosen purely from the request fields.
   function automatic logic [15:0] model_div(input logic custom, input logic [1:0] code,
                                             input logic [15:0] div);
      int tbl [4] = '{651, 326, 163, 81};
      return custom ? div : 16'(tbl[code]);
   endfunction

   task automatic send(input logic custom, input logic [1:0] code, input logic [15:0] div,
                       input int busy);
      int waited = 0;
      while (!req_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before_req", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_custom = custom;
      req_code   = code;
      req_div    = div;
      tx_busy    = (busy > 0);
   endtask

   // Watches edges 1..N after the accept edge (or reset release) and checks the write pair,
   // latency, hold/ready during the sequence and the final programmed divisor.
   task automatic observe(input string name, input logic [15:0] exp_div, input int exp_first,
                          input int exp_done, input int busy_until);
      int         first_w = -1;
      int         done_at = -1;
      int         nw      = 0;
      logic [8:0] w0      = '0;
      logic [8:0] w1      = '0;
      bit         hold_ok = 1'b1;
      bit         line_ok = 1'b1;
      for (int n = 1; n <= exp_done + 40 && done_at < 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            req_valid  = 1'b0;
            req_custom = ~req_custom;
            req_code   = req_code + 2'd1;
            req_div    = 16'($urandom);
         end
         if (n >= busy_until) tx_busy = 1'b0;
         if (baud_write_en) begin
            if (nw == 0) w0 = {baud_write_location, baud_generator_write_line};
            if (nw == 1) w1 = {baud_write_location, baud_generator_write_line};
            if (first_w < 0) first_w = n;
            nw++;
         end else if (baud_generator_write_line != 8'h00) begin
            line_ok = 1'b0;
         end
         if (cfg_done) done_at = n;
         else if (!tx_hold || req_ready) hold_ok = 1'b0;
      end
      check({name, "_done_edge"}, done_at, exp_done);
      check({name, "_hold_at_done"}, {31'd0, tx_hold}, 32'd0);
      check({name, "_ready_at_done"}, {31'd0, req_ready}, 32'd1);
      check({name, "_cur_div"}, {16'd0, cur_div}, {16'd0, exp_div});
      check({name, "_err"}, {31'd0, cfg_err}, 32'd0);
      check({name, "_nwrites"}, nw, 2);
      check({name, "_first_write"}, first_w, exp_first);
      check({name, "_lo"}, {23'd0, w0}, {23'd0, 1'b0, exp_div[7:0]});
      check({name, "_hi"}, {23'd0, w1}, {23'd0, 1'b1, exp_div[15:8]});
      check({name, "_hold_ready_during"}, {31'd0, hold_ok}, 32'd1);
      check({name, "_idle_line"}, {31'd0, line_ok}, 32'd1);
      @(negedge clk);
      check({name, "_done_one_cycle"}, {31'd0, cfg_done}, 32'd0);
   endtask

   task automatic run_req(input string name, input logic custom, input logic [1:0] code,
                          input logic [15:0] div, input int busy);
      logic [15:0] e;
      int          first;
      e     = model_div(custom, code, div);
      first = (busy + 1 > 2) ? busy + 1 : 2;
      send(custom, code, div, busy);
      observe(name, e, first, first + 18, busy);
   endtask

   initial begin
      vec_t        vecs [8];
      logic [15:0] prev;
      int          nw;

      vecs[0] = '{custom: 1'b0, code: 2'b00, div: 16'h0000, busy: 0,  exp_div: 16'd651};
      vecs[1] = '{custom: 1'b0, code: 2'b01, div: 16'hFFFF, busy: 0,  exp_div: 16'd326};
      vecs[2] = '{custom: 1'b0, code: 2'b10, div: 16'h0000, busy: 5,  exp_div: 16'd163};
      vecs[3] = '{custom: 1'b0, code: 2'b11, div: 16'h0000, busy: 0,  exp_div: 16'd81};
      vecs[4] = '{custom: 1'b0, code: 2'b11, div: 16'h0000, busy: 0,  exp_div: 16'd81};
      vecs[5] = '{custom: 1'b1, code: 2'b00, div: 16'h1234, busy: 50, exp_div: 16'h1234};
      vecs[6] = '{custom: 1'b1, code: 2'b10, div: 16'h0001, busy: 1,  exp_div: 16'h0001};
      vecs[7] = '{custom: 1'b1, code: 2'b01, div: 16'hFFFF, busy: 2,  exp_div: 16'hFFFF};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_custom = 1'b0;
      req_code   = 2'b00;
      req_div    = 16'h0000;
      tx_busy    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_hold", {31'd0, tx_hold}, 32'd1);
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_we", {31'd0, baud_write_en}, 32'd0);
      check("rst_line", {24'd0, baud_generator_write_line}, 32'd0);
      check("rst_done_err", {30'd0, cfg_done, cfg_err}, 32'd0);
      check("rst_cur_div", {16'd0, cur_div}, 32'd0);
      rst = 1'b0;
      observe("reset", 16'd326, 1, 19, 0);

      for (int i = 0; i < 8; i++) begin
         int first;
         first = (vecs[i].busy + 1 > 2) ? vecs[i].busy + 1 : 2;
         send(vecs[i].custom, vecs[i].code, vecs[i].div, vecs[i].busy);
         observe($sformatf("vec%0d", i), vecs[i].exp_div, first, first + 18, vecs[i].busy);
      end

      for (int i = 0; i < 20; i++) begin
         logic [15:0] d;
         d = 16'($urandom_range(1, 65535));
         run_req($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), d,
                 int'($urandom_range(0, 30)));
      end

      // Drain timeout: transmitter never goes idle.
      prev = cur_div;
      send(1'b1, 2'b00, 16'h5555, 1);
      nw = 0;
      for (int n = 1; n <= 4097; n++) begin
         @(negedge clk);
         if (n == 1) req_valid = 1'b0;
         if (baud_write_en) nw++;
         if (n == 4096) begin
            check("to_err_early", {31'd0, cfg_err}, 32'd0);
            check("to_hold_draining", {31'd0, tx_hold}, 32'd1);
         end
      end
      check("to_err", {31'd0, cfg_err}, 32'd1);
      check("to_ready", {31'd0, req_ready}, 32'd1);
      check("to_hold", {31'd0, tx_hold}, 32'd0);
      check("to_no_writes", nw, 0);
      check("to_cur_div", {16'd0, cur_div}, {16'd0, prev});
      tx_busy = 1'b0;
      send(1'b0, 2'b10, 16'h0000, 0);
      @(negedge clk);
      check("to_err_cleared", {31'd0, cfg_err}, 32'd0);
      req_valid = 1'b0;
      repeat (30) @(negedge clk);
      check("to_recover_div", {16'd0, cur_div}, 32'd163);

      // Custom divisor of zero is rejected in place.
      prev = cur_div;
      send(1'b1, 2'b00, 16'h0000, 0);
      nw = 0;
      @(negedge clk);
      req_valid = 1'b0;
      check("rej_err", {31'd0, cfg_err}, 32'd1);
      check("rej_ready", {31'd0, req_ready}, 32'd1);
      for (int n = 0; n < 6; n++) begin
         if (baud_write_en || tx_hold) nw++;
         @(negedge clk);
      end
      check("rej_no_activity", nw, 0);
      check("rej_cur_div", {16'd0, cur_div}, {16'd0, prev});
      run_req("rej_clear", 1'b1, 2'b00, 16'h00F0, 0);

      // Reset during the high-byte write restarts with the default divisor.
      send(1'b1, 2'b00, 16'hABCD, 0);
      nw = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 1) req_valid = 1'b0;
         if (baud_write_en && baud_write_location) begin
            nw = n;
            break;
         end
      end
      check("mid_wrhi_edge", nw, 3);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_hold", {31'd0, tx_hold}, 32'd1);
      check("mid_rst_we", {31'd0, baud_write_en}, 32'd0);
      check("mid_rst_done", {31'd0, cfg_done}, 32'd0);
      check("mid_rst_cur_div", {16'd0, cur_div}, 32'd0);
      rst = 1'b0;
      observe("mid_rst", 16'd326, 1, 19, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/baud_rate_ctrl.md
Name: baud_rate_ctrl

Overview:
- Configuration sequencer for the UART baud generator.
- Accepts a rate request, either a preset code or a custom 16-bit divisor, and waits for the transmitter to go idle.
- Drives the generator's byte-wide divisor write port: low byte first, then high byte.
- Holds off new transmissions until the new rate has settled.
- Sits between the processor-side register decode and the baud generator; also loads a default rate after reset.

Parameters:
- DIV_4800, 651, divisor for code 2'b00
- DIV_9600, 326, divisor for code 2'b01
- DIV_19200, 163, divisor for code 2'b10
- DIV_38400, 81, divisor for code 2'b11
- DEFAULT_CODE, 2'b01, preset code loaded after reset
- DRAIN_MAX, 4096, max cycles to wait for tx_busy low before abort
- SETTLE_CYC, 16, cycles tx_hold stays high after the high-byte write

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  rate change request
- req_ready  output  1  high only in IDLE; request accepted when req_valid&&req_ready
- req_custom  input  1  1: use req_div; 0: use preset from req_code
- req_code  input  2  preset rate code
- req_div  input  16  custom divisor
- tx_busy  input  1  transmitter shifting a frame
- tx_hold  output  1  blocks the transmitter from starting a new frame
- baud_write_en  output  1  divisor byte write strobe to baud generator
- baud_write_location  output  1  0 = low byte, 1 = high byte
- baud_generator_write_line  output  8  divisor byte
- cfg_done  output  1  one-cycle pulse when the new divisor is in effect
- cfg_err  output  1  sticky error; cleared on the next accepted request
- cur_div  output  16  divisor currently programmed

Behaviour:
- States: INIT, IDLE, DRAIN, WR_LO, WR_HI, SETTLE.
- Reset (rst high at a clk edge, any state, including mid-write):
  - state=INIT; latched divisor = preset(DEFAULT_CODE).
  - All outputs 0 except tx_hold=1 and cur_div=16'h0000.
  - Counters cleared.
- INIT: one cycle, then WR_LO. DRAIN is skipped after reset.
- IDLE:
  - req_ready=1, tx_hold=0.
  - Accept edge with req_custom=1 and req_div==0: reject. cfg_err=1, no writes, stay IDLE.
  - Accept edge otherwise:
    - Latch divisor: req_div if custom, else preset table.
    - Clear cfg_err; drain counter=0; go to DRAIN.
    - tx_hold=1 from the next cycle.
  - req_valid with req_ready=0: ignored, not queued. The requester must hold req_valid until accepted.
- DRAIN:
  - tx_hold=1.
  - tx_busy=0 sampled: go to WR_LO next cycle.
  - Otherwise increment counter. Counter reaching DRAIN_MAX-1 with tx_busy still high: cfg_err=1, go to IDLE, no writes, cur_div unchanged.
  - tx_hold is already high, so the transmitter cannot start a new frame during DRAIN.
- WR_LO: exactly one cycle. baud_write_en=1, location=0, line=div[7:0].
- WR_HI: exactly one cycle. baud_write_en=1, location=1, line=div[15:8].
- baud_write_en is never high outside WR_LO/WR_HI. Write line is 8'h00 when not writing.
- SETTLE:
  - tx_hold=1; count SETTLE_CYC cycles.
  - On the last count: cycle cfg_done=1, cur_div=latched divisor, then IDLE with tx_hold=0.
- Latency:
  - Accept to first write = 2 cycles if tx_busy already 0: accept edge, DRAIN cycle, WR_LO.
  - Accept to cfg_done = 4+SETTLE_CYC cycles.
  - Reset release to cfg_done = 3+SETTLE_CYC cycles.
- Counters: drain counter 13 bits, settle counter 5 bits; neither wraps (both saturate at their terminal value).
- The same divisor requested again still performs the full sequence.
- Changes to req_* after acceptance have no effect.

Test Plan:
- Reset then idle:
  - Expected writes: (0, 8'h46) then (1, 8'h01) for 326=0x0146.
  - cfg_done 19 cycles after reset release; cur_div=326; tx_hold falls the same edge IDLE is entered.
- Preset code 2'b00 with tx_busy=0:
  - Writes 8'h8B then 8'h02 for 651.
  - cfg_done 20 cycles after accept; req_ready low throughout.
- Custom req_div=16'h1234 with tx_busy high for 50 cycles:
  - tx_hold high from the cycle after accept; no write while busy.
  - Writes 8'h34 then 8'h12 after tx_busy falls; cur_div=16'h1234.
- tx_busy stuck high:
  - cfg_err=1 after 4096 DRAIN cycles; no baud_write_en pulse; cur_div unchanged; tx_hold=0.
  - Next valid request clears cfg_err.
- Custom req_div=0:
  - cfg_err=1 the cycle after accept; zero writes; state stays IDLE.
- rst asserted during WR_HI:
  - Sequence restarts with the default divisor; exactly one low/high pair follows reset.
  - cfg_done does not pulse for the aborted request.
